// File: rtl/riscv_dmem_bridge.sv
// Purpose: turns the riscv_cpu level-held data-memory request into a registered
//          bus_req/bus_ack handshake toward RAM or MMIO, stalling the core until
//          the access retires and faulting misaligned, conflicting or timed-out accesses.
// Ports:   clk/reset (sync, active-high); cpu_* = core side (addr, wdata,
//          mem_write, mem_read in; rdata, stall, fault out); bus_* = memory side
//          (req, write, addr, wdata, mmio out; ack, rdata in).
// Latency: 3 cycles minimum (IDLE -> WAIT with ack -> DONE); back-to-back
//          requests are accepted the cycle after DONE.
module riscv_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] MMIO_BASE      = 32'hFF00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_mem_write,
  input  logic        cpu_mem_read,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_fault,
  output logic        bus_req,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_mmio,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        stall_int;
  logic        req_vld;
  logic        req_bad;
  logic        timeout_hit;

  assign req_vld     = cpu_mem_read | cpu_mem_write;
  // A request is rejected without touching the bus if it is not word aligned
  // or asks for a read and a write at the same time.
  assign req_bad     = (cpu_addr[1:0] != 2'b00) | (cpu_mem_read & cpu_mem_write);
  assign timeout_hit = (wait_cnt == CNT_LAST);

  // The core must see no stall while reset is held, regardless of state.
  assign cpu_stall = stall_int & ~reset;

  always_comb begin
    state_nxt = state;
    stall_int = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_vld) begin
          stall_int = 1'b1;
          state_nxt = req_bad ? S_FAULT : S_WAIT;
        end
      end
      S_WAIT: begin
        stall_int = 1'b1;
        // Ack has priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_mmio  <= 1'b0;
      cpu_rdata <= '0;
      cpu_fault <= 1'b0;
    end else begin
      state <= state_nxt;

      // Counts WAIT cycles already spent; zero on the first WAIT cycle.
      if (state == S_WAIT && state_nxt == S_WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end else begin
        wait_cnt <= '0;
      end

      // bus_req is high exactly while the FSM sits in WAIT.
      bus_req   <= (state_nxt == S_WAIT);
      // The fault pulse coincides with the single FAULT-state cycle.
      cpu_fault <= (state_nxt == S_FAULT);

      // Bus fields are captured once at acceptance and then held, so later
      // changes on the CPU inputs cannot disturb an access in flight.
      if (state == S_IDLE && req_vld && !req_bad) begin
        bus_addr  <= {cpu_addr[31:2], 2'b00};
        bus_wdata <= cpu_wdata;
        bus_write <= cpu_mem_write;
        bus_mmio  <= (cpu_addr >= MMIO_BASE);
      end

      if (state == S_WAIT && bus_ack && !bus_write) begin
        cpu_rdata <= bus_rdata;
      end else if (state == S_FAULT) begin
        cpu_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_bridge.sv
module tb_riscv_dmem_bridge;

  localparam int          TO = 6;
  localparam logic [31:0] MB = 32'hFF00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_mem_write;
  logic        cpu_mem_read;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_fault;
  logic        bus_req;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_mmio;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  riscv_dmem_bridge #(
    .TIMEOUT_CYCLES(TO),
    .MMIO_BASE     (MB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_mem_write(cpu_mem_write),
    .cpu_mem_read (cpu_mem_read),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .cpu_fault    (cpu_fault),
    .bus_req      (bus_req),
    .bus_write    (bus_write),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_mmio     (bus_mmio),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    int          req_cyc;
    int          stall_cyc;
    logic [31:0] rdata;
    logic [31:0] baddr;
    logic        bwrite;
    logic        bmmio;
    logic [31:0] bwdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Reference model: the outcome of one access follows directly from its
  // alignment, its read/write mix and the cycle on which the bus answers
  // (d = WAIT cycle carrying the ack, 0 = never).
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input bit rd,
                       input bit wr, input int d, input logic [31:0] brd);
    exp_t e;
    int   n;
    int   cyc;
    bit   done;
    e.baddr  = a;
    e.bwrite = wr;
    e.bmmio  = (a >= MB);
    e.bwdata = wd;
    if (a[1:0] != 2'b00 || (rd && wr)) begin
      e.fault = 1; e.req_cyc = 0; e.stall_cyc = 1; model_rdata = 32'h0;
    end else if (d >= 1 && d <= TO) begin
      e.fault = 0; e.req_cyc = d; e.stall_cyc = d + 1;
      if (rd) model_rdata = brd;
    end else begin
      e.fault = 1; e.req_cyc = TO; e.stall_cyc = TO + 1; model_rdata = 32'h0;
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);

    cpu_addr      = a;
    cpu_wdata     = wd;
    cpu_mem_read  = rd;
    cpu_mem_write = wr;
    bus_rdata     = brd;
    n = 0; cyc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (bus_req) n++;
      bus_ack = bus_req && (n == d);
      if (!cpu_stall) begin
        done = 1;
      end else if (++cyc > 200) begin
        checks++; errors++;
        $display("FAIL stall_timeout: stall still high after %0d cycles, required release", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
    @(posedge clk); #1;
    cpu_mem_read  = 1'b0;
    cpu_mem_write = 1'b0;
    bus_ack       = 1'b0;
  endtask

  // Monitor: counts what the DUT shows over each access and compares it to
  // the scoreboard entry when the core is released.
  initial begin
    int          st = 0;
    int          rq = 0;
    int          fl = 0;
    bit          bus_bad = 0;
    bit          rd_pend = 0;
    logic [31:0] rd_exp = 32'h0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rd_pend) begin
          check("cpu_rdata", cpu_rdata, rd_exp);
          rd_pend = 0;
        end
        if (cpu_mem_read || cpu_mem_write) begin
          if (cpu_stall) st++;
          if (cpu_fault) fl++;
          if (bus_req) begin
            rq++;
            if (exp_q.size() > 0) begin
              if (bus_addr !== exp_q[0].baddr || bus_write !== exp_q[0].bwrite ||
                  bus_mmio !== exp_q[0].bmmio || bus_wdata !== exp_q[0].bwdata)
                bus_bad = 1;
            end
          end
          if (!cpu_stall) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_retire: got retire, expected none");
            end else begin
              e = exp_q.pop_front();
              check("bus_req_cycles", 32'(rq), 32'(e.req_cyc));
              check("stall_cycles", 32'(st), 32'(e.stall_cyc));
              check("fault_pulses", 32'(fl), {31'h0, e.fault});
              check("bus_fields_ok", {31'h0, bus_bad}, 32'h0);
              rd_exp  = e.rdata;
              rd_pend = 1;
            end
            st = 0; rq = 0; fl = 0; bus_bad = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    int          k;
    reset = 1'b1;
    cpu_addr = 32'h100; cpu_wdata = '0; cpu_mem_read = 1'b1; cpu_mem_write = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stall_in_reset", {31'h0, cpu_stall}, 32'h0);
    check("reset_bus_req", {31'h0, bus_req}, 32'h0);
    check("reset_rdata", cpu_rdata, 32'h0);
    check("reset_fault", {31'h0, cpu_fault}, 32'h0);
    check("reset_bus_addr", bus_addr, 32'h0);
    @(posedge clk); #1;
    cpu_mem_read = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'h0, cpu_stall}, 32'h0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Directed cases
    issue(32'h0000_0100, 32'h0, 1, 0, 1, 32'hDEAD_BEEF);
    issue(32'hFF00_0004, 32'h0000_00A5, 0, 1, 5, 32'h1111_1111);
    issue(32'h0000_0102, 32'h0, 1, 0, 1, 32'h2222_2222);
    issue(32'h0000_0200, 32'h0, 1, 0, 1, 32'h3333_3333);
    issue(32'h0000_0204, 32'h0, 1, 0, 0, 32'h4444_4444);
    issue(32'h0000_0300, 32'h0, 1, 0, TO, 32'h5555_5555);
    issue(32'h0000_0304, 32'h7, 1, 1, 1, 32'h6666_6666);
    issue(32'hFEFF_FFFC, 32'h9, 1, 0, 2, 32'h7777_7777);

    // Randomized accesses, sometimes back-to-back, sometimes with idle gaps
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) a = MB + ($urandom & 32'h00FF_FFFC);
      else       a = $urandom & 32'h00FF_FFFC;
      if (r == 9) a[1:0] = 2'($urandom_range(1, 3));
      k = $urandom_range(0, 9);
      issue(a, $urandom, (k < 5) || (k == 9), (k >= 5), $urandom_range(0, TO + 1), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    #1;
    mon_en = 1'b0;

    // Reset while an access waits on the bus; a late ack must be ignored.
    cpu_addr = 32'h0000_0400; cpu_mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wait_bus_req", {31'h0, bus_req}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_wait_stall", {31'h0, cpu_stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    check("late_ack_bus_req", {31'h0, bus_req}, 32'h0);
    check("late_ack_stall", {31'h0, cpu_stall}, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rdata", cpu_rdata, 32'h0);
    check("late_ack_fault", {31'h0, cpu_fault}, 32'h0);
    check("late_ack_idle_req", {31'h0, bus_req}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
